menu_ctrl_p: RTL
================

# menu_ctrl_p

Parametrised LCD menu controller for the music player: turns debounced single-cycle key pulses into menu navigation and committed playback settings (track, play mode, speed, volume). It generalises the fixed 20-screen menu FSM into three states plus page and cursor registers, with configurable option counts, an idle timeout back to the top menu, and in-play track skipping. It sits between the key debouncers and both the LCD renderer (ui_* outputs) and the audio core (setting outputs).

## Interface
- N_SONG, default 4: number of selectable tracks, ≥2
- N_MODE, default 2: number of play modes, ≥2
- N_SPEED, default 3: number of speeds, ≥2
- N_VOL, default 5: number of volume levels, ≥2
- TIMEOUT_CYC, default 50_000_000: idle cycles in a submenu before auto-return; 0 disables the timeout
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- key_back  in  1  back pulse, 1 cycle
- key_ok  in  1  confirm pulse, 1 cycle
- key_next  in  1  cursor-forward pulse, 1 cycle
- key_prev  in  1  cursor-backward pulse, 1 cycle
- music  out  clog2(N_SONG)  committed track
- mode  out  clog2(N_MODE)  committed play mode
- speed  out  clog2(N_SPEED)  committed speed
- volume  out  clog2(N_VOL)  committed volume
- cfg_changed  out  1  1-cycle pulse on any commit or in-play skip
- ui_state  out  2  TOP=0, SUB=1, PLAY=2
- ui_page  out  2  MUSIC=0, MODE=1, SPEED=2, VOL=3
- ui_cursor  out  CUR_W  highlighted entry; CUR_W = clog2(max(4, N_SONG, N_MODE, N_SPEED, N_VOL))

## Operation
- Simultaneous keys: one key is acted on per cycle. Priority is back > ok > next > prev. The others are dropped.
- Option count N(page): N_SONG, N_MODE, N_SPEED or N_VOL. The TOP menu always has 4 entries.
- Cursor wrap: next at N−1 goes to 0. Prev at 0 goes to N−1.
- TOP state:
  - next/prev move the cursor over the 4 pages.
  - ok sets page = cursor, moves to SUB, and loads the cursor with the page's committed value.
  - back is ignored.
- SUB state:
  - next/prev move the cursor within N(page).
  - back moves to TOP with cursor = page. No commit.
  - ok on page MUSIC: music ← cursor, move to PLAY, pulse cfg_changed.
  - ok on any other page: the page's setting ← cursor, move to TOP with cursor = page, pulse cfg_changed.
- PLAY state:
  - next/prev change music with wrap, pulse cfg_changed, and keep cursor = music.
  - back moves to SUB with page MUSIC and cursor = music.
  - ok is ignored.
- Idle timeout (SUB only, TIMEOUT_CYC > 0):
  - The idle counter clears on any key and on every state change.
  - When the counter equals TIMEOUT_CYC−1 and no key is present that cycle, the next edge moves to TOP with cursor = page. No commit.
  - A key arriving in the expiry cycle wins; no timeout occurs.
- Cursor values are always < N(current page). Settings are always < their N.

## Timing
- All outputs are registered. A key sampled at edge t is reflected in every output after edge t. Latency is 1 cycle, with no extra key-latch stage.
- cfg_changed is high for exactly the cycle following the commit edge and is never high for 2 consecutive cycles unless keys arrive on consecutive cycles.
- Reset values, which apply on any edge where rst=1 including mid-operation and override keys:
  - ui_state = TOP, ui_page = MUSIC, ui_cursor = 0
  - music = mode = speed = volume = 0
  - cfg_changed = 0, idle counter = 0
- Key pulses wider than 1 cycle are acted on every cycle. The debouncer guarantees 1-cycle pulses.

## Structure
- Shared package menu_pkg holds:
  - state enum (TOP/SUB/PLAY)
  - page enum (MUSIC/MODE/SPEED/VOL)
  - key-code enum (NONE/BACK/OK/NEXT/PREV) and the priority function
- Sub-module menu_idle_timer holds the idle counter:
  - inputs: clk, rst, clear, enable
  - output: expire
  - parameter: TIMEOUT_CYC
  - counter width clog2(TIMEOUT_CYC+1)
  - expire is tied to 0 when TIMEOUT_CYC = 0
- The top module holds the state, page, cursor and setting registers.

## Test plan
- Reset then next,next,ok → ui_state=SUB, ui_page=SPEED, ui_cursor=0. Then prev → cursor=2 (wrap). Then ok → speed=2, cfg_changed 1 cycle, state=TOP, cursor=2.
- TOP, ok (MUSIC), next ×3, ok → music=3, state=PLAY. Then next → music=0 (wrap), cfg_changed pulse. Then back → SUB, page=MUSIC, cursor=0.
- Same-cycle back+ok+next in SUB → acts as back only: TOP, no commit, cfg_changed=0.
- TIMEOUT_CYC=16: enter VOL, next, then idle 16 cycles → TOP, cursor=3, volume unchanged. A key at idle cycle 15 instead keeps SUB.
- Assert rst for one cycle while in PLAY with music=2 → all outputs at reset values on the next cycle.
- N_VOL=8 build: commit each of 0..7 → volume matches. Re-entering VOL shows cursor = committed value.

Source files
------------

// File: rtl/menu_pkg.sv
// menu_pkg
// Shared types for the LCD menu controller: UI state, menu page and decoded
// key codes, plus the key priority decoder and a small integer helper used
// to size the cursor.
package menu_pkg;

  typedef enum logic [1:0] {
    ST_TOP  = 2'd0,
    ST_SUB  = 2'd1,
    ST_PLAY = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    PG_MUSIC = 2'd0,
    PG_MODE  = 2'd1,
    PG_SPEED = 2'd2,
    PG_VOL   = 2'd3
  } page_e;

  typedef enum logic [2:0] {
    KEY_NONE = 3'd0,
    KEY_BACK = 3'd1,
    KEY_OK   = 3'd2,
    KEY_NEXT = 3'd3,
    KEY_PREV = 3'd4
  } key_e;

  // Only one key is honoured per cycle: back > ok > next > prev.
  function automatic key_e key_prio(input logic back, input logic ok,
                                    input logic next, input logic prev);
    if (back)      return KEY_BACK;
    else if (ok)   return KEY_OK;
    else if (next) return KEY_NEXT;
    else if (prev) return KEY_PREV;
    else           return KEY_NONE;
  endfunction

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/menu_idle_timer.sv
// menu_idle_timer
// Counts idle cycles while enabled and flags the cycle in which the count
// reaches TIMEOUT_CYC-1. The owner decides whether that flag is acted on.
// Ports:
//   clk    - system clock
//   rst    - synchronous active-high reset
//   clear  - restart the count (a key was seen)
//   enable - count only while high; held at zero otherwise
//   expire - high while the count sits at TIMEOUT_CYC-1 (always 0 if disabled)
module menu_idle_timer #(
  parameter int TIMEOUT_CYC = 50_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  generate
    if (TIMEOUT_CYC == 0) begin : g_off
      // Timeout disabled: no counter at all.
      logic unused_inputs;
      assign unused_inputs = ^{clk, rst, clear, enable};
      assign expire = 1'b0;
    end else begin : g_on
      localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
      logic [CNT_W-1:0] cnt_q;

      assign expire = enable && (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

      // Leaving the enabled state zeroes the count, so every entry into
      // the submenu starts from a fresh count without an explicit clear.
      always_ff @(posedge clk) begin
        if (rst || clear || !enable || expire) begin
          cnt_q <= '0;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end
    end
  endgenerate

endmodule

// File: rtl/menu_ctrl_p.sv
// menu_ctrl_p
// Parametrised LCD menu controller. Turns single-cycle key pulses into
// navigation over a TOP menu (4 pages), a per-page SUB menu and an in-play
// screen, and holds the committed playback settings.
// Ports:
//   clk, rst                       - clock, synchronous active-high reset
//   key_back/ok/next/prev          - debounced 1-cycle key pulses
//   music/mode/speed/volume        - committed settings (registered)
//   cfg_changed                    - 1-cycle pulse on commit or in-play skip
//   ui_state/ui_page/ui_cursor     - screen description for the renderer
module menu_ctrl_p
  import menu_pkg::*;
#(
  parameter int N_SONG      = 4,
  parameter int N_MODE      = 2,
  parameter int N_SPEED     = 3,
  parameter int N_VOL       = 5,
  parameter int TIMEOUT_CYC = 50_000_000,
  localparam int CUR_W = $clog2(imax(imax(4, N_SONG), imax(imax(N_MODE, N_SPEED), N_VOL)))
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       key_back,
  input  logic                       key_ok,
  input  logic                       key_next,
  input  logic                       key_prev,
  output logic [$clog2(N_SONG)-1:0]  music,
  output logic [$clog2(N_MODE)-1:0]  mode,
  output logic [$clog2(N_SPEED)-1:0] speed,
  output logic [$clog2(N_VOL)-1:0]   volume,
  output logic                       cfg_changed,
  output logic [1:0]                 ui_state,
  output logic [1:0]                 ui_page,
  output logic [CUR_W-1:0]           ui_cursor
);

  localparam int MUS_W = $clog2(N_SONG);
  localparam int MOD_W = $clog2(N_MODE);
  localparam int SPD_W = $clog2(N_SPEED);
  localparam int VOL_W = $clog2(N_VOL);

  state_e             state_q;
  page_e              page_q;
  logic [CUR_W-1:0]   cursor_q;
  logic [MUS_W-1:0]   music_q;
  logic [MOD_W-1:0]   mode_q;
  logic [SPD_W-1:0]   speed_q;
  logic [VOL_W-1:0]   volume_q;
  logic               cfg_changed_q;

  key_e               key;
  logic               key_any;
  logic               expire;

  logic [CUR_W-1:0]   cur_last;
  logic [CUR_W-1:0]   cur_inc;
  logic [CUR_W-1:0]   cur_dec;
  logic [CUR_W-1:0]   mus_cur;
  logic [CUR_W-1:0]   mus_last;
  logic [CUR_W-1:0]   mus_inc;
  logic [CUR_W-1:0]   mus_dec;
  logic [CUR_W-1:0]   sel_setting;

  // Highest legal cursor value on each page's submenu.
  function automatic logic [CUR_W-1:0] page_last(input page_e p);
    case (p)
      PG_MUSIC: return CUR_W'(N_SONG - 1);
      PG_MODE:  return CUR_W'(N_MODE - 1);
      PG_SPEED: return CUR_W'(N_SPEED - 1);
      default:  return CUR_W'(N_VOL - 1);
    endcase
  endfunction

  assign key     = key_prio(key_back, key_ok, key_next, key_prev);
  assign key_any = (key != KEY_NONE);

  // The TOP menu always lists the 4 pages regardless of page_q.
  assign cur_last = (state_q == ST_TOP) ? CUR_W'(3) : page_last(page_q);
  assign cur_inc  = (cursor_q == cur_last) ? '0 : cursor_q + 1'b1;
  assign cur_dec  = (cursor_q == '0) ? cur_last : cursor_q - 1'b1;

  // In-play skipping wraps over the track list.
  assign mus_cur  = CUR_W'(music_q);
  assign mus_last = page_last(PG_MUSIC);
  assign mus_inc  = (mus_cur == mus_last) ? '0 : mus_cur + 1'b1;
  assign mus_dec  = (mus_cur == '0) ? mus_last : mus_cur - 1'b1;

  // Committed value of the page highlighted in TOP, used to seed the
  // submenu cursor on entry.
  always_comb begin
    sel_setting = '0;
    case (cursor_q[1:0])
      2'd0:    sel_setting = CUR_W'(music_q);
      2'd1:    sel_setting = CUR_W'(mode_q);
      2'd2:    sel_setting = CUR_W'(speed_q);
      default: sel_setting = CUR_W'(volume_q);
    endcase
  end

  menu_idle_timer #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_idle (
    .clk   (clk),
    .rst   (rst),
    .clear (key_any),
    .enable(state_q == ST_SUB),
    .expire(expire)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_TOP;
      page_q        <= PG_MUSIC;
      cursor_q      <= '0;
      music_q       <= '0;
      mode_q        <= '0;
      speed_q       <= '0;
      volume_q      <= '0;
      cfg_changed_q <= 1'b0;
    end else begin
      cfg_changed_q <= 1'b0;
      case (state_q)
        ST_TOP: begin
          case (key)
            KEY_NEXT: cursor_q <= cur_inc;
            KEY_PREV: cursor_q <= cur_dec;
            KEY_OK: begin
              page_q   <= page_e'(cursor_q[1:0]);
              state_q  <= ST_SUB;
              cursor_q <= sel_setting;
            end
            default: ;
          endcase
        end

        ST_SUB: begin
          case (key)
            KEY_NEXT: cursor_q <= cur_inc;
            KEY_PREV: cursor_q <= cur_dec;
            KEY_BACK: begin
              state_q  <= ST_TOP;
              cursor_q <= CUR_W'(page_q);
            end
            KEY_OK: begin
              cfg_changed_q <= 1'b1;
              case (page_q)
                PG_MUSIC: music_q  <= cursor_q[MUS_W-1:0];
                PG_MODE:  mode_q   <= cursor_q[MOD_W-1:0];
                PG_SPEED: speed_q  <= cursor_q[SPD_W-1:0];
                default:  volume_q <= cursor_q[VOL_W-1:0];
              endcase
              // Choosing a track starts playback; the cursor already
              // equals the new track, which PLAY keeps on screen.
              if (page_q == PG_MUSIC) begin
                state_q <= ST_PLAY;
              end else begin
                state_q  <= ST_TOP;
                cursor_q <= CUR_W'(page_q);
              end
            end
            default: begin
              // A key in the expiry cycle takes precedence over the timeout.
              if (expire) begin
                state_q  <= ST_TOP;
                cursor_q <= CUR_W'(page_q);
              end
            end
          endcase
        end

        ST_PLAY: begin
          case (key)
            KEY_NEXT: begin
              music_q       <= mus_inc[MUS_W-1:0];
              cursor_q      <= mus_inc;
              cfg_changed_q <= 1'b1;
            end
            KEY_PREV: begin
              music_q       <= mus_dec[MUS_W-1:0];
              cursor_q      <= mus_dec;
              cfg_changed_q <= 1'b1;
            end
            KEY_BACK: begin
              state_q  <= ST_SUB;
              page_q   <= PG_MUSIC;
              cursor_q <= mus_cur;
            end
            default: ;
          endcase
        end

        default: begin
          state_q  <= ST_TOP;
          cursor_q <= '0;
        end
      endcase
    end
  end

  assign music       = music_q;
  assign mode        = mode_q;
  assign speed       = speed_q;
  assign volume      = volume_q;
  assign cfg_changed = cfg_changed_q;
  assign ui_state    = state_q;
  assign ui_page     = page_q;
  assign ui_cursor   = cursor_q;

endmodule
